// File: rtl/ervp_onehot_sequence_decoder_pkg.sv
// Shared constants, helpers and step classes
// for the one-hot sequence decoder.
package ervp_onehot_sequence_decoder_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // A one-position vector still needs a 1-bit index
  function automatic int calc_iw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef enum logic [2:0] {
    STEP_FIRST,
    STEP_HOLD,
    STEP_NEXT,
    STEP_WRAP,
    STEP_INIT,
    STEP_BAD
  } step_t;

endpackage

// File: rtl/ervp_onehot_sequence_decoder_if.sv
// Sample/status bundle between a code source
// and the one-hot sequence decoder.
interface ervp_onehot_sequence_decoder_if
  import ervp_onehot_sequence_decoder_pkg::*;
#(
  parameter int COUNT_LENGTH = 4,
  parameter int WRAP_WIDTH   = 8,
  parameter int IW           = calc_iw(COUNT_LENGTH)
);
  logic                    enable;
  logic                    clear;
  logic                    sample;
  logic [COUNT_LENGTH-1:0] onehot_in;
  logic [IW-1:0]           index;
  logic                    index_valid;
  logic                    is_first;
  logic                    is_last;
  logic                    code_error;
  logic                    step_error;
  logic [WRAP_WIDTH-1:0]   wrap_count;

  modport master (
    output enable, clear, sample, onehot_in,
    input  index, index_valid, is_first, is_last,
    input  code_error, step_error, wrap_count
  );

  modport slave (
    input  enable, clear, sample, onehot_in,
    output index, index_valid, is_first, is_last,
    output code_error, step_error, wrap_count
  );
endinterface

// File: rtl/ervp_onehot_to_binary.sv
// One-hot to binary position with zero-hot
// and multi-hot detection.
module ervp_onehot_to_binary #(
  parameter int COUNT_LENGTH = 4,
  parameter int IW           = 2
) (
  input  logic [COUNT_LENGTH-1:0] onehot,
  output logic [IW-1:0]           pos,
  output logic                    zero_hot,
  output logic                    multi_hot
);
  logic seen;

  always_comb begin
    pos       = '0;
    seen      = 1'b0;
    multi_hot = 1'b0;
    for (int i = 0; i < COUNT_LENGTH; i++) begin
      if (onehot[i]) begin
        if (seen) multi_hot = 1'b1;
        seen = 1'b1;
        pos  = IW'(i);
      end
    end
    zero_hot = ~seen;
  end
endmodule

// File: rtl/ervp_onehot_sequence_decoder.sv
// Decodes a stream of one-hot codes, checks the
// step sequence and counts legal wraps.
module ervp_onehot_sequence_decoder
  import ervp_onehot_sequence_decoder_pkg::*;
#(
  parameter int COUNT_LENGTH = 4,
  parameter int UP           = 1,
  parameter int CIRCULAR     = 0,
  parameter int RESET_INDEX  = (UP == 1) ? 0 : COUNT_LENGTH - 1,
  parameter int INIT_INDEX   = RESET_INDEX,
  parameter int WRAP_WIDTH   = 8
) (
  input logic clk,
  input logic rstnn,
  ervp_onehot_sequence_decoder_if.slave bus
);
  localparam int IW = calc_iw(COUNT_LENGTH);

  localparam logic [IW-1:0] FIRST_POS =
    IW'((UP != 0) ? 0 : COUNT_LENGTH - 1);
  localparam logic [IW-1:0] LAST_POS =
    IW'((UP != 0) ? COUNT_LENGTH - 1 : 0);
  localparam logic [IW-1:0] INIT_POS =
    IW'(INIT_INDEX);
  localparam logic [IW-1:0] RESET_POS =
    IW'(RESET_INDEX);

  logic [IW-1:0]         pos;
  logic                  zero_hot;
  logic                  multi_hot;
  logic                  legal;
  logic [IW-1:0]         index_q;
  logic [IW-1:0]         next_pos;
  logic                  valid_q;
  logic                  history_q;
  logic                  code_err_q;
  logic                  step_err_q;
  logic [WRAP_WIDTH-1:0] wrap_q;
  step_t                 step;

  ervp_onehot_to_binary #(
    .COUNT_LENGTH (COUNT_LENGTH),
    .IW           (IW)
  ) u_o2b (
    .onehot    (bus.onehot_in),
    .pos       (pos),
    .zero_hot  (zero_hot),
    .multi_hot (multi_hot)
  );

  assign legal = ~zero_hot & ~multi_hot;

  assign next_pos = (UP != 0) ? index_q + IW'(1)
                              : index_q - IW'(1);

  // Wrap wins over re-init so last->first counts
  // even when the init target is the first slot
  always_comb begin
    step = STEP_FIRST;
    if (history_q) begin
      if (pos == index_q)
        step = STEP_HOLD;
      else if (CIRCULAR != 0 &&
               index_q == LAST_POS &&
               pos == FIRST_POS)
        step = STEP_WRAP;
      else if (index_q != LAST_POS &&
               pos == next_pos)
        step = STEP_NEXT;
      else if (pos == INIT_POS)
        step = STEP_INIT;
      else
        step = STEP_BAD;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      index_q    <= RESET_POS;
      valid_q    <= 1'b0;
      history_q  <= 1'b0;
      code_err_q <= 1'b0;
      step_err_q <= 1'b0;
      wrap_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.enable) begin
        if (bus.clear) begin
          index_q    <= INIT_POS;
          history_q  <= 1'b0;
          code_err_q <= 1'b0;
          step_err_q <= 1'b0;
          wrap_q     <= '0;
        end else if (bus.sample) begin
          if (legal) begin
            index_q   <= pos;
            valid_q   <= 1'b1;
            history_q <= 1'b1;
            if (step == STEP_BAD)
              step_err_q <= 1'b1;
            if (step == STEP_WRAP && wrap_q != '1)
              wrap_q <= wrap_q + 1'b1;
          end else begin
            code_err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = valid_q;
  assign bus.is_first    = (index_q == FIRST_POS);
  assign bus.is_last     = (index_q == LAST_POS);
  assign bus.code_error  = code_err_q;
  assign bus.step_error  = step_err_q;
  assign bus.wrap_count  = wrap_q;
endmodule
